// File: rtl/serial_word_deser.sv
// Serial-to-parallel word deserialiser.
// Assembles a framed 1-bit stream into N-bit raw words and presents them
// through a 1-entry valid/ready holding buffer. A word that completes while
// the buffer is still full is dropped, and the sticky overrun flag is set.
module serial_word_deser #(
  parameter int N         = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_bit_valid,
  input  logic         i_bit,
  input  logic         i_sof,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_busy,
  output logic         o_overrun
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  // Only N-1 bits of partial word are stored; the Nth bit goes straight to o_data.
  logic [N-2:0]    sr_q;
  logic [N-1:0]    data_q;
  logic            valid_q;
  logic            ovr_q;

  logic [N-2:0]    sr_in;
  logic [N-1:0]    word_full;
  logic [N-2:0]    sr_d;
  logic            slot_free;

  // Shift datapath. A start-of-frame bit shifts into an all-zero register, so a
  // fresh frame and a resync use the same path as an ordinary bit.
  always_comb begin
    sr_in     = (state_q == SHIFT && !i_sof) ? sr_q : '0;
    word_full = MSB_FIRST ? {sr_in, i_bit} : {i_bit, sr_in};
    sr_d      = MSB_FIRST ? word_full[N-2:0] : word_full[N-1:1];
    slot_free = !valid_q || i_ready;
  end

  // Frame FSM, bit counter and output holding buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Consumption; a word completing on this same edge overrides below.
      if (valid_q && i_ready) valid_q <= 1'b0;

      if (i_bit_valid) begin
        if (i_sof) begin
          // New frame, or resync that discards any partial word.
          state_q <= SHIFT;
          cnt_q   <= CW'(1);
          sr_q    <= sr_d;
        end else if (state_q == SHIFT) begin
          if (cnt_q == CW'(N-1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            if (slot_free) begin
              data_q  <= word_full;
              valid_q <= 1'b1;
            end else begin
              ovr_q   <= 1'b1;
            end
          end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_overrun = ovr_q;
  assign o_busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_word_deser.sv
// Bench for serial_word_deser: an N=12 MSB-first instance checked every cycle
// against a queue-based frame model, plus an N=20 LSB-first instance with
// directed words.
module tb_serial_word_deser;
  localparam int N  = 12;
  localparam int NB = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic bv, b, sof, rdy;
  logic [N-1:0] data;
  logic valid, busy, ovr;
  logic bbv, bb, bsof, brdy;
  logic [NB-1:0] bdata;
  logic bvalid, bbusy, bovr;

  always #5 clk = ~clk;

  serial_word_deser #(.N(N), .MSB_FIRST(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bv), .i_bit(b), .i_sof(sof),
    .o_data(data), .o_valid(valid), .i_ready(rdy), .o_busy(busy), .o_overrun(ovr)
  );

  serial_word_deser #(.N(NB), .MSB_FIRST(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_valid(bbv), .i_bit(bb), .i_sof(bsof),
    .o_data(bdata), .o_valid(bvalid), .i_ready(brdy), .o_busy(bbusy), .o_overrun(bovr)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: collected frame bits, holding buffer, sticky overrun.
  bit           m_in;
  int           m_bits[$];
  logic [N-1:0] m_data;
  bit           m_valid, m_ovr;
  int           dut_xf;
  int           vhigh;
  int           rdy_mode;  // 0 low, 1 high, 2 random, 3 high only on last bit

  function automatic logic [N-1:0] assemble();
    logic [N-1:0] w = '0;
    for (int i = 0; i < N; i++)
      if (m_bits[i] != 0) w = w | (N'(1) << (N - 1 - i));
    return w;
  endfunction

  task automatic model_clear();
    m_in = 0; m_bits.delete(); m_data = '0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit free, done;
    logic [N-1:0] w;
    free = !m_valid || rdy;
    done = 0;
    w    = '0;
    if (m_valid && rdy) m_valid = 0;
    if (bv) begin
      if (sof) begin
        m_bits.delete(); m_bits.push_back(int'(b)); m_in = 1;
      end else if (m_in) begin
        m_bits.push_back(int'(b));
        if (m_bits.size() == N) begin
          done = 1; w = assemble(); m_in = 0;
        end
      end
    end
    if (done) begin
      if (free) begin m_data = w; m_valid = 1; end
      else m_ovr = 1;
    end
  endtask

  task automatic tick();
    if (valid && rdy) dut_xf++;
    @(posedge clk);
    model_step();
    #1;
    chk("data",    32'(data),  32'(m_data));
    chk("valid",   32'(valid), 32'(m_valid));
    chk("busy",    32'(busy),  32'(m_in));
    chk("overrun", 32'(ovr),   32'(m_ovr));
    if (valid) vhigh++;
  endtask

  function automatic logic pick_rdy(input bit last);
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(1));
      default: return last;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bv = 1'b0; b = 1'($urandom_range(1)); sof = 1'($urandom_range(1));
      rdy = pick_rdy(1'b0);
      tick();
    end
  endtask

  // Sends the first nbits of w (MSB first) with random idle gaps.
  task automatic send(input logic [N-1:0] w, input int gap_pct, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        bv = 1'b0; b = 1'($urandom_range(1)); sof = 1'($urandom_range(1));
        rdy = pick_rdy(1'b0);
        tick();
      end
      bv = 1'b1; b = w[N-1-i]; sof = (i == 0);
      rdy = pick_rdy(i == N - 1);
      tick();
    end
    bv = 1'b0; sof = 1'b0;
  endtask

  task automatic send_b(input logic [NB-1:0] w);
    for (int i = 0; i < NB; i++) begin
      bbv = 1'b1; bb = w[i]; bsof = (i == 0);
      tick();
    end
    bbv = 1'b0; bsof = 1'b0;
    chk("b_valid", 32'(bvalid), 32'd1);
    chk("b_data",  32'(bdata),  32'(w));
    idle(2);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_data",  32'(data),  32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ovr",   32'(ovr),   32'd0);
    chk("rst_bdata", 32'(bdata), 32'd0);
    model_clear();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int x0;
    logic [N-1:0] w;
    rst_n = 1'b0; bv = 0; b = 0; sof = 0; rdy = 0;
    bbv = 0; bb = 0; bsof = 0; brdy = 1'b1;
    dut_xf = 0; vhigh = 0; rdy_mode = 1;
    model_clear();
    #2;
    chk("init_data",  32'(data),  32'd0);
    chk("init_valid", 32'(valid), 32'd0);
    chk("init_busy",  32'(busy),  32'd0);
    chk("init_ovr",   32'(ovr),   32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // 1: 0x800, visible one cycle after last bit; sign-extends negative
    rdy_mode = 1;
    send(12'h800, 0, N);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_data",  32'(data),  32'h800);
    chk("t1_sext",  {{20{data[N-1]}}, data}, 32'hFFFFF800);
    idle(2);

    // 2: 0x7FF with gaps; busy tracked every cycle by the model
    send(12'h7FF, 40, N);
    chk("t2_data", 32'(data), 32'h7FF);
    idle(2);

    // 3: buffer held, second word dropped, then exactly one transfer
    rdy_mode = 0;
    send(12'hABC, 0, N);
    send(12'h123, 20, N);
    chk("t3_data", 32'(data), 32'hABC);
    chk("t3_ovr",  32'(ovr),  32'd1);
    x0 = dut_xf;
    rdy_mode = 1;
    idle(4);
    chk("t3_xfer",  32'(dut_xf - x0), 32'd1);
    chk("t3_valid", 32'(valid), 32'd0);

    // 4: ready on B's last bit frees the slot for B
    do_reset();
    rdy_mode = 0;
    send(12'h5A5, 0, N);
    x0 = dut_xf;
    rdy_mode = 3;
    send(12'h3C3, 0, N);
    chk("t4_ovr",  32'(ovr),  32'd0);
    chk("t4_data", 32'(data), 32'h3C3);
    chk("t4_xfer", 32'(dut_xf - x0), 32'd1);
    rdy_mode = 1;
    idle(2);

    // 5: resync after 5 bits gives exactly one word
    vhigh = 0;
    w = 12'($urandom);
    send(w, 0, 5);
    send(12'h001, 0, N);
    chk("t5_data", 32'(data), 32'h001);
    idle(3);
    chk("t5_count", 32'(vhigh), 32'd1);

    // 6: reset mid-frame, then a clean frame
    send(12'($urandom), 0, 7);
    do_reset();
    send(12'hFFF, 0, N);
    chk("t6_data", 32'(data), 32'hFFF);
    idle(2);

    // random frames, partial frames and random ready
    rdy_mode = 2;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(5) == 0) send(12'($urandom), 30, int'($urandom_range(N - 1, 1)));
      else send(12'($urandom), 30, N);
      idle(int'($urandom_range(2)));
    end
    rdy_mode = 1;
    idle(3);

    // LSB-first, N=20 instance
    send_b(20'h80000);
    send_b(20'h00001);
    send_b(20'($urandom));
    chk("b_ovr", 32'(bovr), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
